shift_engine: RTL and testbench

- Parametrised multi-mode shift register; the successor to the single-step right shifter in the datapath.
- Parallel-loads a word, then executes a commanded multi-bit shift or rotate, one bit per clock, under a start/busy/done handshake.
- Sits between the register file and the ALU result mux. Also serves as a bit-serial source/sink through serial_in/carry.

---
 rtl/shift_engine.sv | 108 ++++++++++
 tb/tb_shift_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/shift_engine.sv
// Multi-mode shift/rotate register: parallel load, then a commanded number of
// single-bit steps (one per clock) under a start/busy/done handshake.
module shift_engine #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  localparam logic [2:0] LSR = 3'b000, LSL = 3'b001, ASR = 3'b010,
                         ROR = 3'b011, ROL = 3'b100, SIR = 3'b101;

  state_t           state, state_nx;
  logic [2:0]       mode_q;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] step_out;
  logic             step_carry;
  logic             last_step;

  assign last_step = (cnt == AMT_W'(1));

  // One step of the latched operation; reserved modes hold out and carry.
  always_comb begin
    step_out   = out;
    step_carry = carry;
    case (mode_q)
      LSR: begin step_out = {1'b0, out[WIDTH-1:1]};        step_carry = out[0];       end
      LSL: begin step_out = {out[WIDTH-2:0], 1'b0};        step_carry = out[WIDTH-1]; end
      ASR: begin step_out = {out[WIDTH-1], out[WIDTH-1:1]}; step_carry = out[0];      end
      ROR: begin step_out = {out[0], out[WIDTH-1:1]};      step_carry = out[0];       end
      ROL: begin step_out = {out[WIDTH-2:0], out[WIDTH-1]}; step_carry = out[WIDTH-1]; end
      SIR: begin step_out = {serial_in, out[WIDTH-1:1]};   step_carry = out[0];       end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // FIN is entered with done already set after a real step; on the zero-amount
  // path it is entered with done clear and spends one extra cycle raising it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !load) state_nx = (amount != '0) ? SHIFT : FIN;
      SHIFT:   if (last_step) state_nx = FIN;
      FIN:     if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      out    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mode_q <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            out <= din;
          end else if (start) begin
            mode_q <= mode;
            cnt    <= amount;
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          out   <= step_out;
          carry <= step_carry;
          cnt   <= cnt - AMT_W'(1);
          if (last_step) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        FIN: begin
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            done <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_engine.sv
// Randomized scoreboard bench for shift_engine: driver pushes expected results,
// a done-triggered monitor pops and compares value, carry and completion cycle.
module tb_shift_engine;
  localparam int W = 8;
  localparam int A = 3;

  logic         clock = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic         start = 1'b0;
  logic [2:0]   mode = '0;
  logic [A-1:0] amount = '0;
  logic         serial_in = 1'b0;
  logic [W-1:0] out;
  logic         carry, busy, done;

  shift_engine #(.WIDTH(W), .AMT_W(A)) dut (
    .clock(clock), .rst(rst), .load(load), .din(din), .start(start),
    .mode(mode), .amount(amount), .serial_in(serial_in),
    .out(out), .carry(carry), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct { logic [8:0] v; int dc; } exp_t;
  exp_t q[$];

  int compared = 0;
  int mismatched = 0;
  logic cur_carry = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Whole-operation reference: result of n steps computed in one shot.
  function automatic logic [8:0] model(logic [2:0] m, int n, logic [7:0] x,
                                       logic s, logic c);
    logic [7:0]        r, t;
    logic signed [7:0] sx;
    logic [15:0]       e, e2;
    if (n == 0 || m >= 3'd6) return {c, x};
    r = x; t = x; sx = x;
    case (m)
      3'd0: begin r = x >> n; t = x >> (n - 1); return {t[0], r}; end
      3'd1: begin r = x << n; t = x << (n - 1); return {t[7], r}; end
      3'd2: begin r = $unsigned(sx >>> n); t = $unsigned(sx >>> (n - 1)); return {t[0], r}; end
      3'd3: begin r = (x >> n) | (x << (8 - n)); return {r[7], r}; end
      3'd4: begin r = (x << n) | (x >> (8 - n)); return {r[0], r}; end
      default: begin
        e  = {{8{s}}, x};
        e2 = e >> n;
        r  = e2[7:0];
        e2 = e >> (n - 1);
        return {e2[0], r};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clock) begin
    if (rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result_out", 32'(out), 32'(e.v[7:0]));
        chk("result_carry", 32'(carry), 32'(e.v[8]));
        chk("done_cycle", 32'(cyc), 32'(e.dc));
      end
    end
  end

  task automatic do_load(logic [7:0] x);
    @(negedge clock);
    load = 1'b1; din = x;
    @(negedge clock);
    load = 1'b0;
    chk("load_out", 32'(out), 32'(x));
    chk("load_carry", 32'(carry), 32'(cur_carry));
  endtask

  task automatic do_op(logic [2:0] m, int n, logic [7:0] x, logic s, bit disturb);
    exp_t e;
    int   dc;
    bit   fin = 0;
    do_load(x);
    e.v = model(m, n, x, s, cur_carry);
    cur_carry = e.v[8];
    dc = cyc + 1 + ((n == 0) ? 1 : n);
    e.dc = dc;
    mode = m; amount = A'(n); serial_in = s; start = 1'b1;
    q.push_back(e);
    for (int i = 0; i < 20 && !fin; i++) begin
      @(negedge clock);
      chk("busy", 32'(busy), 32'(cyc < dc));
      if (cyc >= dc) begin
        start = 1'b0; load = 1'b0; fin = 1;
      end else if (disturb) begin
        load = 1'($urandom); start = 1'($urandom);
        din = 8'($urandom); mode = 3'($urandom); amount = A'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clock);
    chk("idle_after_done", 32'({busy, done}), 32'(0));
    if (q.size() != 0) begin
      chk("done_timeout", 32'(q.size()), 32'(0));
      q.delete();
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out", 32'(out), 32'(0));
    chk("rst_flags", 32'({carry, busy, done}), 32'(0));
    @(negedge clock);
    rst = 1'b1;

    do_load(8'hB5);
    do_op(3'd0, 3, 8'hB5, 1'b0, 0);  // LSR -> 16, carry 1
    do_op(3'd2, 2, 8'h90, 1'b0, 0);  // ASR -> E4
    do_op(3'd4, 3, 8'h81, 1'b0, 0);  // ROL -> 0C
    do_op(3'd5, 4, 8'h00, 1'b1, 0);  // SIR -> F0
    do_op(3'd3, 0, 8'h5A, 1'b0, 0);  // zero amount
    do_op(3'd0, 3, 8'hB5, 1'b0, 1);  // LSR with ignored load/start
    do_op(3'd6, 5, 8'hC3, 1'b1, 0);  // reserved: hold, same timing
    do_op(3'd0, 7, 8'hFF, 1'b0, 0);  // max amount

    // load and start together: load only
    @(negedge clock);
    load = 1'b1; start = 1'b1; din = 8'h3C; mode = 3'd0; amount = 3'd2;
    @(negedge clock);
    load = 1'b0; start = 1'b0;
    chk("ls_out", 32'(out), 32'(8'h3C));
    chk("ls_busy", 32'(busy), 32'(0));
    @(negedge clock);
    chk("ls_idle", 32'({busy, done, out}), 32'({2'b00, 8'h3C}));

    // asynchronous abort mid-ROR
    do_load(8'hA7);
    mode = 3'd3; amount = 3'd6; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 rst = 1'b0;
    #1;
    chk("abort_out", 32'(out), 32'(0));
    chk("abort_flags", 32'({carry, busy, done}), 32'(0));
    q.delete();
    cur_carry = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    do_op(3'd3, 3, 8'h0F, 1'b0, 0);  // ROR after abort -> E1

    for (int k = 0; k < 40; k++)
      do_op(3'($urandom), int'($urandom_range(0, 7)), 8'($urandom), 1'($urandom),
            1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
